// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: arbiter state encoding and grant owner codes.
`timescale 1ns/1ps
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CORE = 2'd1,
        ST_DBG  = 2'd2,
        ST_LOCK = 2'd3
    } arb_st_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_CORE = 2'd1,
        GNT_DBG  = 2'd2
    } gnt_e;

endpackage

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single data_memory port: core load/store path vs debug/loader.
// Grant is combinational; only the ownership history (state + burst count) is registered.
`timescale 1ns/1ps
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          C_REQ,
    input  logic          C_WE,
    input  logic [AW-1:0] C_A,
    input  logic [DW-1:0] C_WD,
    output logic [DW-1:0] C_RD,
    output logic          C_ACK,
    output logic          CORE_STALL,
    input  logic          D_REQ,
    input  logic          D_LOCK,
    input  logic          D_WE,
    input  logic [AW-1:0] D_A,
    input  logic [DW-1:0] D_WD,
    output logic [DW-1:0] D_RD,
    output logic          D_ACK,
    output logic          M_WE,
    output logic [AW-1:0] M_A,
    output logic [DW-1:0] M_WD,
    input  logic [DW-1:0] M_RD
);

    localparam int             BW       = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0]  BCNT_MAX = BW'(MAX_BURST);

    arb_st_e       st_r;
    logic [BW-1:0] bcnt_r;
    logic          under_limit_s;
    gnt_e          gnt_s;

    // A held lock wins unless the burst limit is reached while the core is waiting.
    function automatic gnt_e dmem_arb_grant(input arb_st_e st, input logic c_req,
                                            input logic d_req, input logic under_limit);
        gnt_e g;
        g = GNT_NONE;
        if (st == ST_LOCK && d_req && (under_limit || !c_req)) begin
            g = GNT_DBG;
        end else if (c_req && !d_req) begin
            g = GNT_CORE;
        end else if (d_req && !c_req) begin
            g = GNT_DBG;
        end else if (c_req && d_req) begin
            g = (st == ST_CORE) ? GNT_DBG : GNT_CORE;
        end else begin
            g = GNT_NONE;
        end
        return g;
    endfunction

    // Grant decision and memory-port muxing; reset suppresses every grant.
    always_comb begin
        under_limit_s = (bcnt_r < BCNT_MAX);
        if (RST) begin
            gnt_s = GNT_NONE;
        end else begin
            gnt_s = dmem_arb_grant(st_r, C_REQ, D_REQ, under_limit_s);
        end
        M_WE = 1'b0;
        M_A  = {AW{1'b0}};
        M_WD = {DW{1'b0}};
        case (gnt_s)
            GNT_CORE: begin
                M_WE = C_WE;
                M_A  = C_A;
                M_WD = C_WD;
            end
            GNT_DBG: begin
                M_WE = D_WE;
                M_A  = D_A;
                M_WD = D_WD;
            end
            default: begin
                M_WE = 1'b0;
                M_A  = {AW{1'b0}};
                M_WD = {DW{1'b0}};
            end
        endcase
    end

    assign C_ACK      = (gnt_s == GNT_CORE);
    assign D_ACK      = (gnt_s == GNT_DBG);
    assign CORE_STALL = C_REQ & ~C_ACK;
    assign C_RD       = M_RD;
    assign D_RD       = M_RD;

    // Ownership history: who went last and how long the current debug lock has run.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            st_r   <= ST_IDLE;
            bcnt_r <= {BW{1'b0}};
        end else begin
            case (gnt_s)
                GNT_CORE: begin
                    st_r   <= ST_CORE;
                    bcnt_r <= {BW{1'b0}};
                end
                GNT_DBG: begin
                    if (D_LOCK) begin
                        st_r <= ST_LOCK;
                        if (st_r == ST_LOCK) begin
                            bcnt_r <= under_limit_s ? (bcnt_r + BW'(1)) : bcnt_r;
                        end else begin
                            bcnt_r <= BW'(1);
                        end
                    end else begin
                        st_r   <= ST_DBG;
                        bcnt_r <= {BW{1'b0}};
                    end
                end
                default: begin
                    st_r   <= ST_IDLE;
                    bcnt_r <= {BW{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations, then random traffic
// checked every cycle against an ownership-history reference model.
`timescale 1ns/1ps
module tb_dmem_arbiter;

    localparam int AW        = 32;
    localparam int DW        = 32;
    localparam int MAX_BURST = 4;

    logic          CLK = 1'b0;
    logic          RST, C_REQ, C_WE, D_REQ, D_LOCK, D_WE;
    logic [AW-1:0] C_A, D_A, M_A;
    logic [DW-1:0] C_WD, D_WD, C_RD, D_RD, M_WD, M_RD;
    logic          C_ACK, D_ACK, CORE_STALL, M_WE;

    int vectors    = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
        .CLK(CLK), .RST(RST),
        .C_REQ(C_REQ), .C_WE(C_WE), .C_A(C_A), .C_WD(C_WD), .C_RD(C_RD),
        .C_ACK(C_ACK), .CORE_STALL(CORE_STALL),
        .D_REQ(D_REQ), .D_LOCK(D_LOCK), .D_WE(D_WE), .D_A(D_A), .D_WD(D_WD),
        .D_RD(D_RD), .D_ACK(D_ACK),
        .M_WE(M_WE), .M_A(M_A), .M_WD(M_WD), .M_RD(M_RD)
    );

    // Behavioural stand-in for data_memory: combinational read, write at rising edge.
    logic [DW-1:0] mem [0:255];
    assign M_RD = mem[M_A[7:0]];
    always @(posedge CLK) begin
        if (M_WE) mem[M_A[7:0]] <= M_WD;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: last owner (0 none, 1 core, 2 debug), whether debug holds a lock,
    // and how many locked debug transfers have happened in a row.
    int m_owner  = 0;
    bit m_locked = 1'b0;
    int m_burst  = 0;
    bit last_c_ack = 1'b0;
    bit last_d_ack = 1'b0;

    always @(negedge CLK) begin
        int g;
        logic          e_we;
        logic [AW-1:0] e_a;
        logic [DW-1:0] e_wd;
        if (RST)                                                          g = 0;
        else if (m_locked && D_REQ && (m_burst < MAX_BURST || !C_REQ))    g = 2;
        else if (C_REQ && D_REQ)                                          g = (m_owner == 1) ? 2 : 1;
        else if (C_REQ)                                                   g = 1;
        else if (D_REQ)                                                   g = 2;
        else                                                              g = 0;

        e_we = 1'b0; e_a = '0; e_wd = '0;
        if (g == 1) begin e_we = C_WE; e_a = C_A; e_wd = C_WD; end
        if (g == 2) begin e_we = D_WE; e_a = D_A; e_wd = D_WD; end

        chk("m_c_ack", 64'(C_ACK), 64'(g == 1));
        chk("m_d_ack", 64'(D_ACK), 64'(g == 2));
        chk("m_stall", 64'(CORE_STALL), 64'(C_REQ && g != 1));
        chk("m_we",    64'(M_WE), 64'(e_we));
        chk("m_a",     64'(M_A),  64'(e_a));
        chk("m_wd",    64'(M_WD), 64'(e_wd));
        if (g == 1) chk("m_c_rd", 64'(C_RD), 64'(M_RD));
        if (g == 2) chk("m_d_rd", 64'(D_RD), 64'(M_RD));

        if (g == 1) begin
            m_owner = 1; m_locked = 1'b0; m_burst = 0;
        end else if (g == 2) begin
            m_owner = 2;
            if (D_LOCK) begin
                m_burst  = m_locked ? m_burst + 1 : 1;
                m_locked = 1'b1;
            end else begin
                m_locked = 1'b0; m_burst = 0;
            end
        end else begin
            m_owner = 0; m_locked = 1'b0; m_burst = 0;
        end
        last_c_ack = C_ACK;
        last_d_ack = D_ACK;
    end

    task automatic drive(input logic rst, input logic cr, input logic cwe,
                         input logic [31:0] ca, input logic [31:0] cwd,
                         input logic dr, input logic dl, input logic dwe,
                         input logic [31:0] da, input logic [31:0] dwd);
        @(posedge CLK); #1;
        RST = rst; C_REQ = cr; C_WE = cwe; C_A = ca; C_WD = cwd;
        D_REQ = dr; D_LOCK = dl; D_WE = dwe; D_A = da; D_WD = dwd;
        @(negedge CLK); #1;
    endtask

    initial begin
        logic          cr, cwe, dr, dl, dwe, rs;
        logic [31:0]   ca, cwd, da, dwd;
        logic [9:0]    lock_pat;

        RST = 1'b1; C_REQ = 1'b1; C_WE = 1'b1; C_A = 32'h4; C_WD = 32'h1;
        D_REQ = 1'b1; D_LOCK = 1'b0; D_WE = 1'b1; D_A = 32'h8; D_WD = 32'h2;
        @(negedge CLK); #1;
        chk("rst_c_ack", 64'(C_ACK), 64'd0);
        chk("rst_d_ack", 64'(D_ACK), 64'd0);
        chk("rst_m_we",  64'(M_WE),  64'd0);
        chk("rst_m_a",   64'(M_A),   64'd0);
        chk("rst_stall", 64'(CORE_STALL), 64'd1);

        // Core-only write then read-back.
        drive(1'b0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("wr_c_ack", 64'(C_ACK), 64'd1);
        chk("wr_m_we",  64'(M_WE),  64'd1);
        chk("wr_m_a",   64'(M_A),   64'h10);
        chk("wr_m_wd",  64'(M_WD),  64'hDEADBEEF);
        drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("rd_c_ack", 64'(C_ACK), 64'd1);
        chk("rd_c_rd",  64'(C_RD),  64'hDEADBEEF);

        // Contention from IDLE alternates C,D,C,D.
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 1'b0, 32'h24, 32'h0);
            chk("rr_c_ack", 64'(C_ACK), 64'(i % 2 == 0));
            chk("rr_d_ack", 64'(D_ACK), 64'(i % 2 == 1));
            chk("rr_stall", 64'(CORE_STALL), 64'(i % 2 == 1));
        end

        // Locked bursts from CORE: D,D,D,D,C,D,D,D,D,C (bit 0 first).
        drive(1'b0, 1'b1, 1'b0, 32'h30, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        lock_pat = 10'b10_0001_0000;
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b1, 1'b0, 32'h30, 32'h0, 1'b1, 1'b1, 1'b0, 32'h34, 32'h0);
            chk("lock_c_ack", 64'(C_ACK), 64'(lock_pat[i]));
            chk("lock_d_ack", 64'(D_ACK), 64'(!lock_pat[i]));
        end

        // Dropping D_REQ mid-lock hands the port to the core at once; debug wins next.
        drive(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 1'b1, 1'b0, 32'h44, 32'h0);
        chk("rel_lock_d", 64'(D_ACK), 64'd1);
        drive(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 1'b0, 32'h44, 32'h0);
        chk("rel_c_ack", 64'(C_ACK), 64'd1);
        drive(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 1'b0, 1'b0, 32'h44, 32'h0);
        chk("rel_next_d", 64'(D_ACK), 64'd1);

        // Reset pulse mid-burst with writes pending.
        drive(1'b0, 1'b1, 1'b1, 32'h50, 32'h11, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, 1'b1, 32'h50, 32'h11, 1'b1, 1'b1, 1'b1, 32'h54, 32'h22);
            chk("pre_rst_d", 64'(D_ACK), 64'd1);
        end
        drive(1'b1, 1'b1, 1'b1, 32'h50, 32'h11, 1'b1, 1'b1, 1'b1, 32'h54, 32'h22);
        chk("mid_rst_m_we",  64'(M_WE),  64'd0);
        chk("mid_rst_c_ack", 64'(C_ACK), 64'd0);
        chk("mid_rst_d_ack", 64'(D_ACK), 64'd0);
        chk("mid_rst_stall", 64'(CORE_STALL), 64'd1);
        drive(1'b0, 1'b1, 1'b1, 32'h50, 32'h11, 1'b1, 1'b1, 1'b1, 32'h54, 32'h22);
        chk("post_rst_c", 64'(C_ACK), 64'd1);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 1'b0, 32'h50, 32'h0, 1'b1, 1'b1, 1'b0, 32'h54, 32'h0);
            chk("post_rst_d", 64'(D_ACK), 64'(i < 4));
        end

        // Random traffic; requesters hold a transfer until it is acknowledged.
        cr = 1'b0; cwe = 1'b0; ca = '0; cwd = '0;
        dr = 1'b0; dl = 1'b0; dwe = 1'b0; da = '0; dwd = '0;
        for (int n = 0; n < 3000; n++) begin
            if (!cr || last_c_ack) begin
                cr  = ($urandom_range(0, 9) < 6);
                cwe = 1'($urandom_range(0, 1));
                ca  = 32'($urandom_range(0, 255));
                cwd = $urandom;
            end
            if (!dr || last_d_ack) begin
                dr  = ($urandom_range(0, 9) < 6);
                dwe = 1'($urandom_range(0, 1));
                da  = 32'($urandom_range(0, 255));
                dwd = $urandom;
                dl  = ($urandom_range(0, 9) < 7);
            end else if ($urandom_range(0, 19) == 0) begin
                dr = 1'b0;
            end
            rs = ($urandom_range(0, 99) == 0);
            drive(rs, cr, cwe, ca, cwd, dr, dl, dwe, da, dwd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
